// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the pipeline hazard scoreboard: FSM states, the
// load-result marker and the Execute operand forwarding selects.
package hazard_scoreboard_pkg;

    // Hazard control FSM states
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } hazard_state_t;

    // result_src_e value that marks the Execute instruction as a load
    localparam logic [1:0] RESULT_SRC_MEMORY = 2'b01;

    // Raw select code produced by forward_select, shared by both operands
    localparam logic [1:0] FWD_SEL_REG = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;

    // Operand A source select in Execute
    typedef enum logic [1:0] {
        EXECUTE_RD1       = FWD_SEL_REG,
        WRITE_BACK_RESULT = FWD_SEL_WB,
        MEMORY_ALU_RESULT = FWD_SEL_MEM
    } hazard_forward_a_t;

    // Operand B source select in Execute (same encoding as operand A)
    typedef enum logic [1:0] {
        EXECUTE_RD2         = FWD_SEL_REG,
        WRITE_BACK_RESULT_B = FWD_SEL_WB,
        MEMORY_ALU_RESULT_B = FWD_SEL_MEM
    } hazard_forward_b_t;

    // Pipeline-register controls driven by the scoreboard
    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic stallM;
        logic flushD;
        logic flushE;
    } hazard_ctrl_t;

    // Every stage frozen while the data memory is busy
    localparam hazard_ctrl_t CTRL_MEM_WAIT = '{stallF: 1'b1, stallD: 1'b1, stallE: 1'b1,
                                              stallM: 1'b1, flushD: 1'b0, flushE: 1'b0};
    // Hold Fetch/Decode and push a bubble into Execute
    localparam hazard_ctrl_t CTRL_BUBBLE   = '{stallF: 1'b1, stallD: 1'b1, stallE: 1'b0,
                                              stallM: 1'b0, flushD: 1'b0, flushE: 1'b1};
    // Squash the two wrong-path instructions behind a taken branch
    localparam hazard_ctrl_t CTRL_REDIRECT = '{stallF: 1'b0, stallD: 1'b0, stallE: 1'b0,
                                              stallM: 1'b0, flushD: 1'b1, flushE: 1'b1};

endpackage

// File: rtl/hazard_scoreboard_forward_select.sv
// One Execute operand source select: the youngest in-flight producer wins,
// and register x0 is never forwarded because it always reads as zero.
module forward_select
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rsE,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic                  regWriteM,
    input  logic                  regWriteW,
    output logic [1:0]            fwdSel
);

    logic rsIsZero;

    assign rsIsZero = (rsE == '0);

    // Memory stage result has priority over Writeback (it is younger)
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves fwdSel
        // unassigned, which would otherwise infer a latch.
        fwdSel = FWD_SEL_REG;
        if (!rsIsZero && regWriteM && (rsE == rdM)) begin
            fwdSel = FWD_SEL_MEM;
        end else if (!rsIsZero && regWriteW && (rsE == rdW)) begin
            fwdSel = FWD_SEL_WB;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a five-stage pipeline: operand forwarding, load-use
// bubbles, data-memory wait stalls, branch flushes and saturating
// stall/flush performance counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic [1:0]            result_src_e,
    input  logic                  pc_src_e,
    input  logic                  mem_busy_m,
    output hazard_forward_a_t     forward_a_e,
    output hazard_forward_b_t     forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    // Bubbles still owed after the one inserted in the detecting cycle
    localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_BUBBLES - 1);

    hazard_state_t    state;
    hazard_state_t    stateNext;
    logic [1:0]       bcnt;
    logic [1:0]       bcntNext;
    hazard_ctrl_t     ctrl;
    logic             loadUse;
    logic [1:0]       fwdSelA;
    logic [1:0]       fwdSelB;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    // ------------------------------------------------------------------
    // Forwarding: one selector per Execute source operand
    // ------------------------------------------------------------------
    forward_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .rsE       (rs1_e),
        .rdM       (rd_m),
        .rdW       (rd_w),
        .regWriteM (reg_write_m),
        .regWriteW (reg_write_w),
        .fwdSel    (fwdSelA)
    );

    forward_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .rsE       (rs2_e),
        .rdM       (rd_m),
        .rdW       (rd_w),
        .regWriteM (reg_write_m),
        .regWriteW (reg_write_w),
        .fwdSel    (fwdSelB)
    );

    assign forward_a_e = hazard_forward_a_t'(fwdSelA);
    assign forward_b_e = hazard_forward_b_t'(fwdSelB);

    // A load in Execute whose destination is read by the Decode instruction
    assign loadUse = (result_src_e == RESULT_SRC_MEMORY) && (rd_e != '0)
                   && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State and bubble-counter register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (reset) begin
            state <= RUN;
            bcnt  <= 2'd0;
        end else begin
            state <= stateNext;
            bcnt  <= bcntNext;
        end
    end

    // Next-state selection: memory wait beats branch redirect beats load-use
    always_comb begin
        stateNext = state;
        bcntNext  = bcnt;
        case (state)
            // MEM_WAIT falls back to run rules in the cycle the memory
            // finishes, so that cycle can already redirect or stall.
            RUN, MEM_WAIT: begin
                if (mem_busy_m) begin
                    stateNext = MEM_WAIT;
                    bcntNext  = 2'd0;
                end else if (pc_src_e) begin
                    stateNext = RUN;
                end else if (loadUse && (LOAD_BUBBLES > 1)) begin
                    stateNext = LOAD_STALL;
                    bcntNext  = BUBBLE_RELOAD;
                end else begin
                    stateNext = RUN;
                end
            end
            // A memory stall abandons the remaining bubbles: the load's
            // result will be ready once the memory completes.
            LOAD_STALL: begin
                if (mem_busy_m) begin
                    stateNext = MEM_WAIT;
                    bcntNext  = 2'd0;
                end else if (bcnt <= 2'd1) begin
                    stateNext = RUN;
                    bcntNext  = 2'd0;
                end else begin
                    bcntNext  = bcnt - 2'd1;
                end
            end
            default: begin
                stateNext = RUN;
                bcntNext  = 2'd0;
            end
        endcase
    end

    // Stall/flush decode from the current state and inputs, held low in reset
    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (mem_busy_m) begin
                        ctrl = CTRL_MEM_WAIT;
                    end else if (pc_src_e) begin
                        // The load is on the wrong path: flushing it is enough
                        ctrl = CTRL_REDIRECT;
                    end else if (loadUse) begin
                        ctrl = CTRL_BUBBLE;
                    end
                end
                LOAD_STALL: begin
                    ctrl = mem_busy_m ? CTRL_MEM_WAIT : CTRL_BUBBLE;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign stall_f = ctrl.stallF;
    assign stall_d = ctrl.stallD;
    assign stall_e = ctrl.stallE;
    assign stall_m = ctrl.stallM;
    assign flush_d = ctrl.flushD;
    assign flush_e = ctrl.flushE;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------

    // Saturating counts of fetch-stall cycles and Decode flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (ctrl.stallF && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if (ctrl.flushD && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stallCount;
    assign flush_events = flushCount;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: three scoreboards (LOAD_BUBBLES 1/3/4, CNT_W 32/32/4)
// share one stimulus stream; a behavioural model checks every cycle, a
// vector table checks single-cycle decisions and hand sequences check the
// multi-cycle corner cases with constant expectations.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NDUT = 3;
    localparam int LBS[NDUT] = '{1, 3, 4};
    localparam int CWS[NDUT] = '{32, 32, 4};

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [5:0]  ctl;   // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
        logic [31:0] sc;
        logic [31:0] fev;
    } obs_t;

    typedef struct packed {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       rwM, rwW;
        logic [1:0] rsrc;
        logic       pc, busy;
        logic [1:0] fa, fb;
        logic [5:0] ctl;
    } vec_t;

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_MEM   = 6'b111100;
    localparam logic [5:0] C_BUB   = 6'b110001;
    localparam logic [5:0] C_FLUSH = 6'b000011;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regWriteM, regWriteW, pcSrcE, memBusyM;
    logic [1:0] resultSrcE;

    hazard_forward_a_t fa0, fa1, fa2;
    hazard_forward_b_t fb0, fb1, fb2;
    logic [5:0]  ctl0, ctl1, ctl2;
    logic [31:0] sc0, fev0, sc1, fev1;
    logic [3:0]  sc2, fev2;
    obs_t        obsA[NDUT];

    int total = 0;
    int bad   = 0;

    // Model state: bubbles still owed after the current cycle, counter values
    int     bubLeft[NDUT];
    longint stallCnt[NDUT];
    longint flushCnt[NDUT];
    obs_t   expNow[NDUT];

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_BUBBLES(1), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .rs1_d(rs1D), .rs2_d(rs2D), .rs1_e(rs1E), .rs2_e(rs2E),
        .rd_e(rdE), .rd_m(rdM), .rd_w(rdW), .reg_write_m(regWriteM), .reg_write_w(regWriteW),
        .result_src_e(resultSrcE), .pc_src_e(pcSrcE), .mem_busy_m(memBusyM),
        .forward_a_e(fa0), .forward_b_e(fb0), .stall_f(ctl0[5]), .stall_d(ctl0[4]),
        .stall_e(ctl0[3]), .stall_m(ctl0[2]), .flush_d(ctl0[1]), .flush_e(ctl0[0]),
        .stall_cycles(sc0), .flush_events(fev0));

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_BUBBLES(3), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .rs1_d(rs1D), .rs2_d(rs2D), .rs1_e(rs1E), .rs2_e(rs2E),
        .rd_e(rdE), .rd_m(rdM), .rd_w(rdW), .reg_write_m(regWriteM), .reg_write_w(regWriteW),
        .result_src_e(resultSrcE), .pc_src_e(pcSrcE), .mem_busy_m(memBusyM),
        .forward_a_e(fa1), .forward_b_e(fb1), .stall_f(ctl1[5]), .stall_d(ctl1[4]),
        .stall_e(ctl1[3]), .stall_m(ctl1[2]), .flush_d(ctl1[1]), .flush_e(ctl1[0]),
        .stall_cycles(sc1), .flush_events(fev1));

    hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_BUBBLES(4), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .rs1_d(rs1D), .rs2_d(rs2D), .rs1_e(rs1E), .rs2_e(rs2E),
        .rd_e(rdE), .rd_m(rdM), .rd_w(rdW), .reg_write_m(regWriteM), .reg_write_w(regWriteW),
        .result_src_e(resultSrcE), .pc_src_e(pcSrcE), .mem_busy_m(memBusyM),
        .forward_a_e(fa2), .forward_b_e(fb2), .stall_f(ctl2[5]), .stall_d(ctl2[4]),
        .stall_e(ctl2[3]), .stall_m(ctl2[2]), .flush_d(ctl2[1]), .flush_e(ctl2[0]),
        .stall_cycles(sc2), .flush_events(fev2));

    assign obsA[0] = {fa0, fb0, ctl0, sc0, fev0};
    assign obsA[1] = {fa1, fb1, ctl1, sc1, fev1};
    assign obsA[2] = {fa2, fb2, ctl2, 28'd0, sc2, 28'd0, fev2};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [1:0] fwd_code(input logic [4:0] rs);
        if (rs != 0 && regWriteM && rs == rdM) return 2'd2;   // Memory ALU result
        if (rs != 0 && regWriteW && rs == rdW) return 2'd1;   // Writeback result
        return 2'd0;                                          // register file
    endfunction

    function automatic bit load_use();
        return resultSrcE == 2'b01 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    endfunction

    function automatic obs_t expect_out(input int k);
        obs_t o;
        o     = '0;
        o.fa  = fwd_code(rs1E);
        o.fb  = fwd_code(rs2E);
        o.sc  = 32'(stallCnt[k]);
        o.fev = 32'(flushCnt[k]);
        if (!reset) begin
            if (memBusyM)          o.ctl = C_MEM;
            else if (bubLeft[k] > 0) o.ctl = C_BUB;
            else if (pcSrcE)       o.ctl = C_FLUSH;
            else if (load_use())   o.ctl = C_BUB;
        end
        return o;
    endfunction

    function automatic void model_update(input int k, input obs_t o);
        longint maxCnt;
        maxCnt = (longint'(1) << CWS[k]) - 1;
        if (reset) begin
            bubLeft[k]  = 0;
            stallCnt[k] = 0;
            flushCnt[k] = 0;
        end else begin
            if (o.ctl[5] && stallCnt[k] < maxCnt) stallCnt[k]++;
            if (o.ctl[1] && flushCnt[k] < maxCnt) flushCnt[k]++;
            if (memBusyM)            bubLeft[k] = 0;
            else if (bubLeft[k] > 0) bubLeft[k]--;
            else if (pcSrcE)         bubLeft[k] = 0;
            else if (load_use())     bubLeft[k] = LBS[k] - 1;
        end
    endfunction

    // One clock: compare every DUT against the model, then advance the model
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            expNow[k] = expect_out(k);
            check($sformatf("model_dut%0d", k), 80'(obsA[k]), 80'(expNow[k]));
        end
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) model_update(k, expNow[k]);
        #1;
    endtask

    task automatic zero_in();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {regWriteM, regWriteW, pcSrcE, memBusyM} = '0;
        resultSrcE = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        zero_in();
        tick();
        reset = 1'b0;
    endtask

    vec_t vecs[11];
    int   busyLeft;

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            bubLeft[k] = 0; stallCnt[k] = 0; flushCnt[k] = 0;
        end
        reset = 1'b1;
        zero_in();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        #1;
        check("reset_ctl", 80'(ctl1), 80'(C_NONE));
        check("reset_cnt", 80'({sc1, fev1}), 80'(0));

        // ---------------- single-cycle vector table (dut0) ----------------
        vecs[0]  = '{rs1E: 5, rdM: 5, rwM: 1, rdW: 5, rwW: 1, fa: MEMORY_ALU_RESULT, default: '0};
        vecs[1]  = '{rs1E: 0, rdM: 5, rwM: 1, rdW: 5, rwW: 1, fa: EXECUTE_RD1, default: '0};
        vecs[2]  = '{rs2E: 9, rdM: 3, rwM: 1, rdW: 9, rwW: 1, fb: WRITE_BACK_RESULT, default: '0};
        vecs[3]  = '{rs1E: 4, rs2E: 4, rdM: 4, rwM: 0, rdW: 4, rwW: 1,
                     fa: WRITE_BACK_RESULT, fb: WRITE_BACK_RESULT, default: '0};
        vecs[4]  = '{rsrc: 2'b01, rdE: 7, rs1D: 7, ctl: C_BUB, default: '0};
        vecs[5]  = '{rsrc: 2'b01, rdE: 0, rs1D: 0, ctl: C_NONE, default: '0};
        vecs[6]  = '{rsrc: 2'b00, rdE: 7, rs1D: 7, ctl: C_NONE, default: '0};
        vecs[7]  = '{rsrc: 2'b10, rdE: 7, rs2D: 7, ctl: C_NONE, default: '0};
        vecs[8]  = '{pc: 1, ctl: C_FLUSH, default: '0};
        vecs[9]  = '{busy: 1, pc: 1, rsrc: 2'b01, rdE: 3, rs2D: 3, ctl: C_MEM, default: '0};
        vecs[10] = '{ctl: C_NONE, default: '0};
        for (int i = 0; i < 11; i++) begin
            rs1D = vecs[i].rs1D; rs2D = vecs[i].rs2D; rs1E = vecs[i].rs1E; rs2E = vecs[i].rs2E;
            rdE = vecs[i].rdE; rdM = vecs[i].rdM; rdW = vecs[i].rdW;
            regWriteM = vecs[i].rwM; regWriteW = vecs[i].rwW; resultSrcE = vecs[i].rsrc;
            pcSrcE = vecs[i].pc; memBusyM = vecs[i].busy;
            #1;
            check($sformatf("vec%0d_fa", i), 80'(fa0), 80'(vecs[i].fa));
            check($sformatf("vec%0d_fb", i), 80'(fb0), 80'(vecs[i].fb));
            check($sformatf("vec%0d_ctl", i), 80'(ctl0), 80'(vecs[i].ctl));
            tick();
        end

        // ---------------- load-use, 3 bubbles (dut1) ----------------
        do_reset();
        resultSrcE = 2'b01; rdE = 7; rs2D = 7;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("lu3_c%0d", c), 80'(ctl1), 80'(c <= 3 ? C_BUB : C_NONE));
            if (c == 4) check("lu3_stall_cycles", 80'(sc1), 80'(3));
            tick();
            zero_in();
        end

        // ---------------- memory wait, 4 cycles (all) ----------------
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            zero_in();
            memBusyM = (c <= 4);
            pcSrcE   = (c == 2 || c == 5);
            #1;
            if (c <= 4) check($sformatf("memwait_c%0d", c), 80'(ctl0), 80'(C_MEM));
            if (c == 5) check("memwait_run_again", 80'(ctl0), 80'(C_FLUSH));
            if (c == 6) check("memwait_counts", 80'({sc0, fev0}), 80'({32'd4, 32'd1}));
            tick();
        end

        // ---------------- load-use together with branch (dut1) ----------------
        do_reset();
        resultSrcE = 2'b01; rdE = 6; rs1D = 6; pcSrcE = 1'b1;
        #1;
        check("lu_pc_ctl", 80'(ctl1), 80'(C_FLUSH));
        tick();
        zero_in();
        #1;
        check("lu_pc_no_stall", 80'(ctl1), 80'(C_NONE));
        check("lu_pc_flush_events", 80'(fev1), 80'(1));
        tick();

        // ---------------- reset during LOAD_STALL (dut2, 4 bubbles) ----------------
        do_reset();
        resultSrcE = 2'b01; rdE = 2; rs1D = 2;
        tick();
        zero_in();
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_count_before", 80'(sc2), 80'(2));
        check("rst_mid_outputs_gated", 80'(ctl2), 80'(C_NONE));
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_after", 80'({fa2, fb2, ctl2, sc2, fev2}), 80'(0));
        tick();
        #1;
        check("rst_mid_still_run", 80'(ctl2), 80'(C_NONE));
        tick();

        // ---------------- counter saturation (dut2, CNT_W=4) ----------------
        do_reset();
        memBusyM = 1'b1;
        repeat (20) tick();
        memBusyM = 1'b0;
        #1;
        check("sat_stall_cnt4", 80'(sc2), 80'(15));
        check("sat_stall_cnt32", 80'(sc0), 80'(20));
        tick();

        // ---------------- randomized run against the model ----------------
        do_reset();
        busyLeft = 0;
        for (int c = 0; c < 2000; c++) begin
            reset      = ($urandom_range(0, 149) == 0);
            rs1D       = 5'($urandom_range(0, 3));
            rs2D       = 5'($urandom_range(0, 3));
            rs1E       = 5'($urandom_range(0, 3));
            rs2E       = 5'($urandom_range(0, 3));
            rdE        = 5'($urandom_range(0, 3));
            rdM        = 5'($urandom_range(0, 3));
            rdW        = 5'($urandom_range(0, 3));
            regWriteM  = 1'($urandom_range(0, 1));
            regWriteW  = 1'($urandom_range(0, 1));
            resultSrcE = 2'($urandom_range(0, 3));
            pcSrcE     = ($urandom_range(0, 5) == 0);
            if (busyLeft > 0) begin
                memBusyM = 1'b1;
                busyLeft--;
            end else if ($urandom_range(0, 9) == 0) begin
                memBusyM = 1'b1;
                busyLeft = int'($urandom_range(0, 3));
            end else begin
                memBusyM = 1'b0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, width of register-index ports.
REQ-002 SHALL have parameter LOAD_BUBBLES, default 1, legal 1..4, number of bubbles inserted per load-use hazard.
REQ-003 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-004 SHALL have one clock and a synchronous, active-high reset. The ports are listed in REQ-005 to REQ-015.
REQ-005 SHALL have ports clk (input, 1 bit, rising-edge clock) and reset (input, 1 bit, synchronous active-high reset).
REQ-006 SHALL have inputs rs1_d and rs2_d (REG_ADDR_W bits each), the source registers of the Decode instruction.
REQ-007 SHALL have inputs rs1_e, rs2_e and rd_e (REG_ADDR_W bits each), the source and destination registers of the Execute instruction.
REQ-008 SHALL have inputs rd_m and rd_w (REG_ADDR_W bits each), the destination registers in Memory and Writeback.
REQ-009 SHALL have inputs reg_write_m and reg_write_w (1 bit each), the register-write enables in Memory and Writeback.
REQ-010 SHALL have input result_src_e (2 bits). The value RESULT_SRC_MEMORY marks the Execute instruction as a load.
REQ-011 SHALL have input pc_src_e (1 bit), high when a taken branch or jump resolves in Execute.
REQ-012 SHALL have input mem_busy_m (1 bit), high while the data memory has not completed the access in Memory.
REQ-013 SHALL have outputs forward_a_e (hazard_forward_a_t) and forward_b_e (hazard_forward_b_t), the Execute operand source selects.
REQ-014 SHALL have outputs stall_f, stall_d, stall_e, stall_m, flush_d and flush_e (1 bit each), the pipeline-register controls.
REQ-015 SHALL have outputs stall_cycles and flush_events (CNT_W bits each), the performance counters.

Function
REQ-016 forward_a_e SHALL be combinational with this priority:
- MEMORY_ALU_RESULT when rs1_e==rd_m, reg_write_m is high and rs1_e!=0;
- else WRITE_BACK_RESULT when rs1_e==rd_w, reg_write_w is high and rs1_e!=0;
- else EXECUTE_RD1.
REQ-017 forward_b_e SHALL follow the same rule as REQ-016 using rs2_e; its default is EXECUTE_RD2.
REQ-018 A load-use hazard (lu) SHALL be detected when result_src_e==RESULT_SRC_MEMORY, rd_e!=0, and rd_e equals rs1_d or rs2_d.
REQ-019 The FSM SHALL have three states: RUN, LOAD_STALL and MEM_WAIT. A bubble-remaining counter (bcnt) SHALL be 2 bits wide.
REQ-020 Event priority SHALL be, from highest: mem_busy_m, then pc_src_e, then lu.
REQ-021 RUN behaviour SHALL be:
- if mem_busy_m is high: assert stall_f, stall_d, stall_e and stall_m combinationally, and go to MEM_WAIT;
- else if pc_src_e is high: assert flush_d and flush_e, and stay in RUN;
- else if lu is high: assert stall_f, stall_d and flush_e; go to LOAD_STALL with bcnt=LOAD_BUBBLES-1 if LOAD_BUBBLES>1, otherwise stay in RUN.
REQ-022 LOAD_STALL SHALL assert stall_f, stall_d and flush_e and decrement bcnt each cycle. When bcnt reaches 0 it SHALL return to RUN. If mem_busy_m rises, it SHALL go to MEM_WAIT and abandon the remaining bubbles.
REQ-023 MEM_WAIT SHALL assert stall_f, stall_d, stall_e and stall_m, with no flushes. pc_src_e SHALL be ignored in this state. It SHALL return to RUN in the cycle after mem_busy_m falls, and in that RUN cycle REQ-021 applies.
REQ-024 When lu and pc_src_e are high together, the unit SHALL flush only: no stall and no LOAD_STALL entry.
REQ-025 stall_cycles SHALL increment in every cycle where stall_f is high, saturating at all-ones.
REQ-026 flush_events SHALL increment in every cycle where flush_d is high, saturating at all-ones.
REQ-027 All stall and flush outputs SHALL be combinational functions of the state and the current inputs, with zero-cycle latency.

Reset
REQ-028 Reset SHALL return the FSM to RUN, clear bcnt to 0, and clear both counters to 0, from any state including mid-stall.
REQ-029 While reset is high, all stall and flush outputs SHALL be 0. Forward selects SHALL remain the combinational functions defined in REQ-016 and REQ-017.

Structure
REQ-030 hazard_state_t and RESULT_SRC_MEMORY (2'b01) SHALL be declared in the shared types header, alongside hazard_forward_a_t and hazard_forward_b_t.
REQ-031 A sub-module forward_select SHALL compute one operand select and SHALL be instantiated twice.

Verification
REQ-032 Forwarding: rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_a_e=MEMORY_ALU_RESULT. With rs1_e=0 under the same conditions -> EXECUTE_RD1.
REQ-033 Load-use with LOAD_BUBBLES=3: result_src_e=01, rd_e=7, rs2_d=7 -> stall_f, stall_d and flush_e high for exactly 3 cycles, and stall_cycles=3.
REQ-034 Memory wait: mem_busy_m high for 4 cycles -> all four stalls high for 4 cycles, flush_d stays 0 even with pc_src_e=1 in the 2nd cycle, and the FSM is in RUN in the 5th cycle.
REQ-035 Simultaneous lu and pc_src_e -> flush_d=1, flush_e=1, stall_f=0, and flush_events increments by 1.
REQ-036 Reset asserted in the 2nd cycle of LOAD_STALL (LOAD_BUBBLES=4) -> on the next edge the FSM is in RUN, all outputs are 0 and both counters are 0.
REQ-037 Saturation: preload with CNT_W=4 and apply 20 stall cycles -> stall_cycles holds at 15.
